// File: rtl/wb_demux.sv
// Write-back demultiplexer: a 2-entry in-order buffer drained one entry per
// permitted cycle into six registered destinations. Optional macro: WB_DEMUX_ERR_EN.
module wb_demux #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic [2:0]  in_dest,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        drain_en,
    output logic [15:0] out0,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3,
    output logic [15:0] out4,
    output logic [15:0] out5,
    output logic [5:0]  ld,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [15:0]   r_mem_data [DEPTH];
    logic [2:0]    r_mem_dest [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_out [6];
    logic [5:0]    r_ld;

    logic          w_enq;
    logic          w_deq;
    logic [15:0]   w_head_data;
    logic [2:0]    w_head_dest;
    logic          w_head_ok;

    // Readiness is forced low during reset so nothing is taken in that cycle.
    assign in_ready    = rst_n && (r_cnt < CW'(DEPTH));
    assign w_enq       = in_valid && in_ready;
    assign w_deq       = drain_en && (r_cnt != '0);
    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_dest = r_mem_dest[r_rptr];
    assign w_head_ok   = (w_head_dest < 3'd6);

    // Storage needs no reset: entries only become visible through r_cnt.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_data[r_wptr] <= in_data;
            r_mem_dest[r_wptr] <= in_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ld   <= '0;
            for (int i = 0; i < 6; i++) r_out[i] <= '0;
        end else begin
            r_ld <= '0;
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
                if (w_head_ok) begin
                    r_out[w_head_dest] <= w_head_data;
                    r_ld               <= 6'd1 << w_head_dest;
                end
            end
            if (w_enq && !w_deq)      r_cnt <= r_cnt + 1'b1;
            else if (!w_enq && w_deq) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef WB_DEMUX_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (!rst_n)                       r_err <= 1'b0;
        else if (w_deq && !w_head_ok)     r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign out0 = r_out[0];
    assign out1 = r_out[1];
    assign out2 = r_out[2];
    assign out3 = r_out[3];
    assign out4 = r_out[4];
    assign out5 = r_out[5];
    assign ld   = r_ld;
    assign busy = (r_cnt != '0);
endmodule

// File: doc/wb_demux.md
WB_DEMUX -- requirements
Module: wb_demux

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of pending-write buffer entries (fixed at 2; other values unsupported).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_data, input, 16 bits: write-back value.
REQ-005 SHALL have port in_dest, input, 3 bits: destination select, 0..5 valid.
REQ-006 SHALL have port in_valid, input, 1 bit: the {in_data, in_dest} pair is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-008 SHALL have port drain_en, input, 1 bit: downstream permits one buffered write this cycle.
REQ-009 SHALL have ports out0..out5, output, 16 bits each: registered destination values.
REQ-010 SHALL have port ld, output, 6 bits: one-hot pulse; ld[n] marks that outn was updated at the previous edge.
REQ-011 SHALL have port busy, output, 1 bit: buffer non-empty.
REQ-012 SHALL have port err, output, 1 bit: sticky out-of-range destination flag (see Configuration).

Function
REQ-013 SHALL hold accepted writes in an in-order FIFO of 2 entries of {data[15:0], dest[2:0]}, with a count of 0..2.
REQ-014 SHALL drive in_ready = (count < 2) combinationally, with no dependence on drain_en.
REQ-015 SHALL accept and enqueue at an edge when in_valid and in_ready are both high; while in_valid is low, in_data and in_dest are ignored.
REQ-016 SHALL dequeue the head at an edge when drain_en is high and count > 0; drain_en with count = 0 has no effect.
REQ-017 SHALL, on dequeuing a head with dest n in 0..5, load outn with the head data at that edge and assert ld to the one-hot value for n for exactly the following cycle.
REQ-018 SHALL, on dequeuing a head with dest 6 or 7, leave out0..out5 unchanged and hold ld at 0.
REQ-019 SHALL hold ld at 0 in any cycle following an edge with no dequeue.
REQ-020 SHALL, on a simultaneous accept and dequeue, leave count unchanged and preserve order (new entry behind the remaining entries).
REQ-021 SHALL have a minimum latency of 2 edges: accept at edge k into an empty FIFO, outn updated at edge k+1 if drain_en is high in the cycle after edge k.
REQ-022 SHALL provide no same-cycle bypass: an entry is never written to an output at the edge on which it is accepted.
REQ-023 SHALL, when full (count = 2), hold in_ready low; a dequeue at that edge raises in_ready for the next cycle.
REQ-024 SHALL drive busy = (count != 0), registered-state derived.

Reset
REQ-025 SHALL, at an edge where rst_n is low, clear count to 0, out0..out5 to 16'h0000, ld to 0 and err to 0, and discard buffered entries.
REQ-026 SHALL drive in_ready low while rst_n is low, and high in the first cycle after release.
REQ-027 SHALL, when reset is asserted mid-operation, drop all pending entries without any output write, even if drain_en is high at that edge.

Configuration
REQ-028 SHALL use macro WB_DEMUX_ERR_EN to control the error flag.
REQ-029 SHALL, with WB_DEMUX_ERR_EN defined, set err at any edge dequeuing a dest of 6 or 7 and hold it until reset.
REQ-030 SHALL, with WB_DEMUX_ERR_EN undefined, tie err to constant 0 with no err register present; all other behaviour is identical.

Verification
REQ-031 SHALL cover single write: in_data=16'hBEEF, in_dest=3 accepted, drain_en=1 next cycle -> out3=16'hBEEF after 2 edges, ld=6'b001000 for one cycle, other outputs 0.
REQ-032 SHALL cover back-pressure: drain_en=0, three valid offers (16'h0001/d0, 16'h0002/d1, 16'h0003/d2) -> first two accepted, in_ready=0 on the third; drain_en=1 -> out0=1, then out1=2, then the third is accepted.
REQ-033 SHALL cover simultaneous events: count=1 with accept and drain at the same edge -> count stays 1, outputs updated in FIFO order.
REQ-034 SHALL cover out-of-range: in_dest=7 with 16'h1234, drained -> no outn change, ld=0; err=1 if WB_DEMUX_ERR_EN is defined, else 0.
REQ-035 SHALL cover reset mid-operation: FIFO full, rst_n=0 for one edge with drain_en=1 -> all outputs 0, busy=0, in_ready=1 after release, no ld pulse.
